// File: rtl/sha_round_seq_if.sv
// Block-level handshakes of the SHA-2 round sequencer.
// The start handshake carries the block attributes, and the done handshake closes each block.
interface sha_round_seq_if;
    logic start_valid;
    logic start_ready;
    logic start_mode;
    logic start_first;
    logic done_valid;
    logic done_ready;

    modport master (
        output start_valid, start_mode, start_first, done_ready,
        input  start_ready, done_valid
    );

    modport slave (
        input  start_valid, start_mode, start_first, done_ready,
        output start_ready, done_valid
    );
endinterface

// File: rtl/sha_round_seq.sv
// Round sequencer for the SHA-2 compression core (SHA-256: 64 rounds, SHA-512: 80 rounds).
// Drives the external round counter and cross-checks it against an internal shadow count.
//
// state  | meaning
// IDLE   | waiting for a block, counter held in init
// LOAD   | load working variables from IV or H, counter held in init
// ROUND  | rounds 0..Lm1, counter running
// FINAL  | last round (63 / 79)
// UPDATE | H += working variables
// DONE   | done_valid held until done_ready
module sha_round_seq (
    input  logic                  clk,
    input  logic                  rst,
    sha_round_seq_if.slave        hs,
    input  logic                  abort,
    output logic                  ctr_init,
    output logic                  ctr_mode,
    input  logic [6:0]            ctr_round,
    input  logic                  ctr_round_last,
    output logic                  core_load,
    output logic                  iv_sel,
    output logic                  core_en,
    output logic [6:0]            round_idx,
    output logic                  core_update,
    output logic                  busy,
    output logic                  err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_ROUND  = 3'd2;
    localparam logic [2:0] S_FINAL  = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       mode_q;
    logic       first_q;
    logic [6:0] shadow;
    logic [6:0] lm1;
    logic       at_last;
    logic       mismatch;
    logic       accept;

    assign lm1      = mode_q ? 7'd78 : 7'd62;
    assign at_last  = (shadow == lm1);
    assign accept   = (state == S_IDLE) && hs.start_valid;

    // In FINAL the shadow has moved past Lm1, so a healthy counter shows round_last=0 there.
    assign mismatch = (ctr_round != shadow)
                    || (ctr_round_last && !at_last)
                    || (at_last && !ctr_round_last);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (hs.start_valid) state_nxt = S_LOAD;
            S_LOAD:   state_nxt = S_ROUND;
            S_ROUND:  if (ctr_round_last || at_last) state_nxt = S_FINAL;
            S_FINAL:  state_nxt = S_UPDATE;
            S_UPDATE: state_nxt = S_DONE;
            S_DONE:   if (hs.done_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (abort && (state != S_IDLE)) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            err     <= 1'b0;
            mode_q  <= 1'b0;
            first_q <= 1'b0;
            shadow  <= 7'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                mode_q  <= hs.start_mode;
                first_q <= hs.start_first;
                err     <= 1'b0;
            end
            // The shadow bounds ROUND on its own, so a silent counter cannot stretch the block.
            if (state == S_LOAD)
                shadow <= 7'd0;
            else if (state == S_ROUND)
                shadow <= shadow + 7'd1;
            if (((state == S_ROUND) || (state == S_FINAL)) && mismatch)
                err <= 1'b1;
        end
    end

    assign hs.start_ready = (state == S_IDLE);
    assign hs.done_valid  = (state == S_DONE);
    assign ctr_init       = (state == S_IDLE) || (state == S_LOAD);
    assign ctr_mode       = mode_q;
    assign core_load      = (state == S_LOAD);
    assign iv_sel         = (state == S_LOAD) && first_q;
    assign core_en        = (state == S_ROUND) || (state == S_FINAL);
    assign round_idx      = ctr_round;
    assign core_update    = (state == S_UPDATE);
    assign busy           = (state != S_IDLE);

endmodule

// File: tb/tb_sha_round_seq.sv
// Directed bench for sha_round_seq with a behavioural round-counter model that can be faulted.
module tb_sha_round_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       abort;
    logic       ctr_init;
    logic       ctr_mode;
    logic [6:0] ctr_round;
    logic       ctr_round_last;
    logic       core_load;
    logic       iv_sel;
    logic       core_en;
    logic [6:0] round_idx;
    logic       core_update;
    logic       busy;
    logic       err;

    sha_round_seq_if bus ();

    sha_round_seq dut (
        .clk            (clk),
        .rst            (rst),
        .hs             (bus.slave),
        .abort          (abort),
        .ctr_init       (ctr_init),
        .ctr_mode       (ctr_mode),
        .ctr_round      (ctr_round),
        .ctr_round_last (ctr_round_last),
        .core_load      (core_load),
        .iv_sel         (iv_sel),
        .core_en        (core_en),
        .round_idx      (round_idx),
        .core_update    (core_update),
        .busy           (busy),
        .err            (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Counter model: 0 = healthy, 1 = round_last at 40, 2 = round_last never, 3 = round 3 reads as 2
    int         fault_mode = 0;
    logic [6:0] cnt;

    always @(posedge clk) begin
        if (ctr_init) cnt <= 7'd0;
        else          cnt <= cnt + 7'd1;
    end

    always_comb begin
        ctr_round      = cnt;
        ctr_round_last = (cnt == (ctr_mode ? 7'd78 : 7'd62));
        if (fault_mode == 1)
            ctr_round_last = (cnt == 7'd40);
        else if (fault_mode == 2)
            ctr_round_last = 1'b0;
        else if ((fault_mode == 3) && (cnt == 7'd3))
            ctr_round = 7'd2;
    end

    int         n_acc, acc0, acc1, n_load, n_en, idx_bad, n_upd, upd_cyc, dv_cyc, n_dv;
    logic [6:0] en_idx;
    logic [7:0] iv_hist;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.start_valid && bus.start_ready) begin
                if (n_acc == 0)      acc0 = cyc;
                else if (n_acc == 1) acc1 = cyc;
                n_acc++;
            end
            if (core_load) begin
                n_load++;
                iv_hist = {iv_hist[6:0], iv_sel};
                en_idx  = 7'd0;
            end
            if (core_en) begin
                if (round_idx !== en_idx) idx_bad++;
                en_idx = en_idx + 7'd1;
                n_en++;
            end
            if (core_update) begin
                n_upd++;
                upd_cyc = cyc;
            end
            if (bus.done_valid && (dv_cyc < 0)) dv_cyc = cyc;
            if (bus.done_valid && bus.done_ready) n_dv++;
        end
    end

    task automatic clear_log();
        n_acc = 0; acc0 = -1; acc1 = -1; n_load = 0; n_en = 0; idx_bad = 0;
        n_upd = 0; upd_cyc = -1; dv_cyc = -1; n_dv = 0; en_idx = 7'd0; iv_hist = 8'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input logic m, input logic f);
        int k;
        bus.start_mode  = m;
        bus.start_first = f;
        bus.start_valid = 1'b1;
        step();
        bus.start_valid = 1'b0;
        k = 0;
        while (!((n_dv >= 1) && bus.start_ready) && (k < 200)) begin
            step();
            k++;
        end
        total++;
        if (k >= 200) begin
            bad++;
            $display("FAIL run_block_timeout: done_handshakes=%0d required>=1", n_dv);
        end
    endtask

    task automatic test_reset();
        logic [9:0] obs;
        rst = 1'b1; abort = 1'b0;
        bus.start_valid = 1'b0; bus.start_mode = 1'b0; bus.start_first = 1'b0; bus.done_ready = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        obs = {bus.start_ready, ctr_init, busy, core_load, core_en, core_update,
               bus.done_valid, err, ctr_mode, iv_sel};
        total++;
        if (obs !== 10'b11_0000_0000) begin
            bad++;
            $display("FAIL reset_outputs: got %b required %b", obs, 10'b11_0000_0000);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_sha256();
        clear_log();
        run_block(1'b0, 1'b1);
        total++;
        if ((n_load != 1) || (iv_hist[0] !== 1'b1)) begin
            bad++;
            $display("FAIL sha256_load: loads=%0d iv=%b required 1 and 1", n_load, iv_hist[0]);
        end
        total++;
        if (n_en != 64) begin
            bad++;
            $display("FAIL sha256_en_count: got %0d required 64", n_en);
        end
        total++;
        if (idx_bad != 0) begin
            bad++;
            $display("FAIL sha256_round_idx: bad indices=%0d required 0", idx_bad);
        end
        total++;
        if ((n_upd != 1) || (upd_cyc - acc0 != 66)) begin
            bad++;
            $display("FAIL sha256_update: count=%0d offset=%0d required 1 at 66", n_upd, upd_cyc - acc0);
        end
        total++;
        if (dv_cyc - acc0 != 67) begin
            bad++;
            $display("FAIL sha256_done_time: offset=%0d required 67", dv_cyc - acc0);
        end
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL sha256_err: got %b required 0", err);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        clear_log();
        bus.start_mode  = 1'b1;
        bus.start_first = 1'b1;
        bus.start_valid = 1'b1;
        step();
        bus.start_first = 1'b0;
        k = 0;
        while ((n_acc < 2) && (k < 200)) begin
            step();
            k++;
        end
        bus.start_valid = 1'b0;
        total++;
        if (n_acc < 2) begin
            bad++;
            $display("FAIL b2b_second_accept: accepts=%0d required 2", n_acc);
        end
        k = 0;
        while (!((n_dv >= 2) && bus.start_ready) && (k < 200)) begin
            step();
            k++;
        end
        total++;
        if (acc1 - acc0 != 84) begin
            bad++;
            $display("FAIL b2b_period: got %0d required 84", acc1 - acc0);
        end
        total++;
        if ((n_en != 160) || (idx_bad != 0)) begin
            bad++;
            $display("FAIL b2b_rounds: en=%0d bad_idx=%0d required 160 and 0", n_en, idx_bad);
        end
        total++;
        if ((n_load != 2) || (iv_hist[1:0] !== 2'b10)) begin
            bad++;
            $display("FAIL b2b_iv_sel: loads=%0d iv=%b required 2 and 10", n_load, iv_hist[1:0]);
        end
        total++;
        if ((n_upd != 2) || (n_dv != 2) || (err !== 1'b0)) begin
            bad++;
            $display("FAIL b2b_completion: upd=%0d done=%0d err=%b required 2 2 0", n_upd, n_dv, err);
        end
    endtask

    task automatic test_backpressure();
        int k;
        clear_log();
        bus.done_ready  = 1'b0;
        bus.start_mode  = 1'b0;
        bus.start_first = 1'b1;
        bus.start_valid = 1'b1;
        step();
        bus.start_valid = 1'b0;
        k = 0;
        while ((bus.done_valid !== 1'b1) && (k < 100)) begin
            step();
            k++;
        end
        total++;
        if (bus.done_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_done_arrives: got %b required 1", bus.done_valid);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if ((bus.done_valid !== 1'b1) || (bus.start_ready !== 1'b0)) begin
                bad++;
                $display("FAIL bp_hold: cycle %0d done_valid=%b start_ready=%b required 1 0",
                         i, bus.done_valid, bus.start_ready);
            end
        end
        bus.done_ready = 1'b1;
        step();
        total++;
        if ((bus.start_ready !== 1'b1) || (busy !== 1'b0) || (bus.done_valid !== 1'b0)) begin
            bad++;
            $display("FAIL bp_release: start_ready=%b busy=%b done_valid=%b required 1 0 0",
                     bus.start_ready, busy, bus.done_valid);
        end
    endtask

    task automatic test_abort();
        int k;
        clear_log();
        bus.start_mode  = 1'b0;
        bus.start_first = 1'b1;
        bus.start_valid = 1'b1;
        step();
        bus.start_valid = 1'b0;
        k = 0;
        while (!(core_en && (round_idx == 7'd30)) && (k < 100)) begin
            step();
            k++;
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        total++;
        if ((bus.start_ready !== 1'b1) || (ctr_init !== 1'b1) || (busy !== 1'b0)) begin
            bad++;
            $display("FAIL abort_idle: start_ready=%b ctr_init=%b busy=%b required 1 1 0",
                     bus.start_ready, ctr_init, busy);
        end
        repeat (80) step();
        total++;
        if ((n_upd != 0) || (dv_cyc >= 0)) begin
            bad++;
            $display("FAIL abort_no_completion: updates=%0d done_seen=%0d required 0 and -1", n_upd, dv_cyc);
        end
        clear_log();
        run_block(1'b0, 1'b0);
        total++;
        if ((n_en != 64) || (n_dv != 1) || (err !== 1'b0)) begin
            bad++;
            $display("FAIL abort_restart: en=%0d done=%0d err=%b required 64 1 0", n_en, n_dv, err);
        end
    endtask

    task automatic test_faulty_counter();
        int k;
        fault_mode = 1;
        clear_log();
        run_block(1'b0, 1'b1);
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL early_last_err: got %b required 1", err);
        end
        total++;
        if ((n_en != 42) || (upd_cyc - acc0 != 44) || (n_dv != 1)) begin
            bad++;
            $display("FAIL early_last_timing: en=%0d upd_offset=%0d done=%0d required 42 44 1",
                     n_en, upd_cyc - acc0, n_dv);
        end
        fault_mode = 2;
        clear_log();
        run_block(1'b0, 1'b1);
        total++;
        if ((err !== 1'b1) || (n_en != 64) || (upd_cyc - acc0 != 66)) begin
            bad++;
            $display("FAIL missing_last: err=%b en=%0d upd_offset=%0d required 1 64 66",
                     err, n_en, upd_cyc - acc0);
        end
        fault_mode = 0;
        clear_log();
        bus.start_mode  = 1'b0;
        bus.start_first = 1'b0;
        bus.start_valid = 1'b1;
        step();
        bus.start_valid = 1'b0;
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_clear_on_accept: got %b required 0", err);
        end
        k = 0;
        while (!((n_dv >= 1) && bus.start_ready) && (k < 200)) begin
            step();
            k++;
        end
        total++;
        if ((err !== 1'b0) || (n_dv != 1)) begin
            bad++;
            $display("FAIL healthy_after_fault: err=%b done=%0d required 0 1", err, n_dv);
        end
    endtask

    task automatic test_mid_reset();
        int k;
        logic [9:0] obs;
        fault_mode = 3;
        clear_log();
        bus.start_mode  = 1'b1;
        bus.start_first = 1'b1;
        bus.start_valid = 1'b1;
        step();
        bus.start_valid = 1'b0;
        k = 0;
        while (!(core_en && (round_idx == 7'd10)) && (k < 100)) begin
            step();
            k++;
        end
        total++;
        if ((err !== 1'b1) || (ctr_mode !== 1'b1)) begin
            bad++;
            $display("FAIL pre_reset_state: err=%b ctr_mode=%b required 1 1", err, ctr_mode);
        end
        rst = 1'b1;
        step();
        obs = {bus.start_ready, ctr_init, busy, core_load, core_en, core_update,
               bus.done_valid, err, ctr_mode, iv_sel};
        total++;
        if (obs !== 10'b11_0000_0000) begin
            bad++;
            $display("FAIL mid_reset_outputs: got %b required %b", obs, 10'b11_0000_0000);
        end
        total++;
        if ((ctr_mode !== 1'b0) || (err !== 1'b0)) begin
            bad++;
            $display("FAIL mid_reset_regs: ctr_mode=%b err=%b required 0 0", ctr_mode, err);
        end
        rst = 1'b0;
        fault_mode = 0;
        step();
    endtask

    initial begin
        clear_log();
        test_reset();
        test_sha256();
        test_back_to_back();
        test_backpressure();
        test_abort();
        test_faulty_counter();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sha_round_seq.md
# sha_round_seq

Round sequencer for the SHA-2 compression core. It accepts one message block per start handshake and selects SHA-256 (64 rounds) or SHA-512 (80 rounds). It drives the round counter's `init`/`mode` inputs and consumes its `round`/`round_last` outputs, pulsing load, round-enable and update strobes into the datapath. A result handshake closes each block. It cross-checks the counter against an internal shadow count and flags disagreement.

## Interface
- No parameters.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_valid`  in  1  a block is ready in the message buffer.
- `start_ready`  out  1  sequencer can accept a block.
- `start_mode`  in  1  0 = SHA-256, 1 = SHA-512; sampled on accept.
- `start_first`  in  1  first block of a message (load IV); sampled on accept.
- `abort`  in  1  cancel the current block, return to IDLE.
- `ctr_init`  out  1  to round counter `init`.
- `ctr_mode`  out  1  to round counter `mode` (latched mode).
- `ctr_round`  in  7  round counter `round`.
- `ctr_round_last`  in  1  round counter `round_last` (high at round 62 / 78).
- `core_load`  out  1  load working variables A..H.
- `iv_sel`  out  1  with `core_load`: 1 = from IV, 0 = from H.
- `core_en`  out  1  execute one round using `round_idx`.
- `round_idx`  out  7  round index for K/W lookup, equal to `ctr_round`.
- `core_update`  out  1  H += working variables.
- `done_valid`  out  1  digest state updated for this block.
- `done_ready`  in  1  downstream accepts the done indication.
- `busy`  out  1  state is not IDLE.
- `err`  out  1  sticky counter-disagreement flag.

## Operation
- States: IDLE, LOAD, ROUND, FINAL, UPDATE, DONE. Outputs decode from the state register. `err`, `mode_q`, `first_q` and the 7-bit `shadow` are registers.
- **IDLE**
  - Outputs: `start_ready`=1, `ctr_init`=1.
  - On `start_valid`: latch `mode_q`/`first_q`, clear `err`, go to LOAD.
- **LOAD**
  - Outputs: `core_load`=1, `iv_sel`=`first_q`, `ctr_init`=1.
  - Sets `shadow`=0. Goes to ROUND.
- **ROUND**
  - Outputs: `core_en`=1, `ctr_init`=0. `shadow` increments each cycle.
  - Let Lm1 = 62 (mode 0) or 78 (mode 1).
  - Go to FINAL when `ctr_round_last`=1 or `shadow`==Lm1, whichever comes first.
- **FINAL**
  - Outputs: `core_en`=1 for exactly one cycle (round 63 / 79). Goes to UPDATE.
- **UPDATE**
  - Outputs: `core_update`=1 for one cycle. Goes to DONE.
- **DONE**
  - Outputs: `done_valid`=1, held until `done_ready`, then go to IDLE.
  - `start_ready`=0 in DONE, so no overlap.
- `ctr_mode`=`mode_q` at all times. `round_idx`=`ctr_round`.
- `err` is set in ROUND or FINAL when any of the following holds:
  - `ctr_round` != `shadow`;
  - `ctr_round_last`=1 while `shadow` != Lm1;
  - `shadow`==Lm1 while `ctr_round_last`=0.
- `err` persists until the next accepted start or `rst`. The round sequence never exceeds 64 / 80 `core_en` cycles, even on error.
- `abort`=1 in any state except IDLE goes to IDLE next cycle. No `core_update` and no `done_valid` are produced. `err` is unchanged. `abort` takes priority over all other transitions.
- `rst` forces IDLE with `err`=0, `mode_q`=0, `first_q`=0, `shadow`=0. This holds mid-block too.

## Timing
- Reset values (cycle after `rst` edge):
  - `start_ready`=1, `ctr_init`=1;
  - `busy`, `core_load`, `core_en`, `core_update`, `done_valid`, `err`, `ctr_mode`, `iv_sel`=0.
- Accept at edge T (IDLE, `start_valid`&`start_ready`). Then:
  - T+1: LOAD.
  - SHA-256: ROUND T+2..T+64 (rounds 0..62), FINAL T+65, UPDATE T+66, `done_valid` from T+67.
  - SHA-512: ROUND T+2..T+80, FINAL T+81, UPDATE T+82, `done_valid` from T+83.
- The counter sees `init`=1 through LOAD, so `ctr_round`=0 in the first ROUND cycle.
- `done_valid` & `done_ready` at edge D: IDLE at D+1. The next block's earliest accept is at D+1, so minimum block period is 68 / 84 cycles.
- `start_valid` while not IDLE is ignored; upstream holds it.
- `abort` and `done_ready` in the same DONE cycle: IDLE either way, with the handshake counted as not completed.

## Test plan
- **SHA-256 single block:** reset, then `start_valid`=1, `mode`=0, `first`=1, `done_ready`=1 with a correct counter model.
  - One `core_load` with `iv_sel`=1.
  - Exactly 64 `core_en` pulses with `round_idx` 0..63.
  - `core_update` at T+66, `done_valid` at T+67, `err`=0.
- **SHA-512 back-to-back:** `mode`=1, `first`=1 then `first`=0, `done_ready`=1.
  - 80 `core_en` pulses per block; second block has `iv_sel`=0.
  - Second accept exactly 84 cycles after the first.
- **Done backpressure:** `done_ready`=0 for 10 cycles.
  - `done_valid` held; `start_ready`=0 throughout.
  - IDLE one cycle after `done_ready` rises.
- **Abort:** `abort` at the cycle with `round_idx`=30.
  - IDLE next cycle, `ctr_init`=1.
  - No `core_update`, no `done_valid`.
  - A new start then completes normally.
- **Faulty counter:**
  - Model asserts `ctr_round_last` at round 40 → `err`=1, FINAL next cycle, `done_valid` still produced.
  - Model never asserts it → FINAL forced after round 62, `err`=1.
  - Next accepted start clears `err`.
- **Mid-block reset:** `rst` at round 10.
  - All outputs at reset values next cycle.
  - `ctr_mode`=0, `err`=0.
